multi_port_memory_controller: RTL
=================================

// Module: multi_port_memory_controller
// PURPOSE
//  Successor to the single-client SDRAM front end: arbitrates NUM_PORTS independent read/write
//  clients plus a refresh requester onto one SDRAM driver command interface. Round-robin between
//  ports, refresh has top priority, per-port ack and read-valid strobes, parametrised widths and
//  latency. Sits between the VDP/CPU-side clients and the sdram driver; adds fail/write statistics.
// PARAMETERS
//  NUM_PORTS     4   number of client channels (1..8)
//  ADDR_W        22  client address width; mem_addr is ADDR_W+1 wide, MSB always 0
//  DATA_W        16  data width (multiple of 8)
//  ACCESS_CYCLES 4   cycles from command issue to completion/read-data sample (>=2)
//  CNT_W         20  width of total_written counter
// PORTS
//  clk           in   1                 main logic clock, all logic on rising edge
//  resetn        in   1                 synchronous active-low reset
//  req_read      in   NUM_PORTS         per-port read request, level, hold until ack
//  req_write     in   NUM_PORTS         per-port write request, level, hold until ack
//  req_addr      in   NUM_PORTS*ADDR_W  per-port address, port p at [p*ADDR_W +: ADDR_W]
//  req_din       in   NUM_PORTS*DATA_W  per-port write data
//  req_wdm       in   NUM_PORTS*DATA_W/8 per-port byte write mask (1 = byte masked)
//  req_ack       out  NUM_PORTS         one-cycle pulse: request captured
//  rd_valid      out  NUM_PORTS         one-cycle pulse: rd_data valid for that port
//  rd_data       out  DATA_W            last read data, held until next read completes
//  refresh       in   1                 refresh request, level, hold until refresh_ack
//  refresh_ack   out  1                 one-cycle pulse: refresh captured
//  busy          out  1                 1 during init or while an access is in flight
//  mem_rd/mem_wr/mem_refresh out 1      one-cycle command pulses to sdram driver
//  mem_addr      out  ADDR_W+1          command address;  mem_din out DATA_W; mem_wdm out DATA_W/8
//  mem_busy      in   1                 driver busy (init sequence)
//  mem_dout      in   DATA_W            driver read data;  mem_data_ready in 1
//  fail          out  1                 sticky: data_ready missing at sample, or read+write same port
//  total_written out  CNT_W             count of accepted writes, wraps
// BEHAVIOUR
//  - Reset: state=INIT, busy=1, all strobes/commands 0, rd_data=0, fail=0, total_written=0,
//    rr pointer=0. Reset mid-access abandons it; no ack/valid emitted afterwards.
//  - INIT: wait for mem_busy=0, then IDLE next cycle with busy=0. Requests ignored in INIT.
//  - IDLE: refresh=1 -> refresh_ack, mem_refresh pulse. Else pick first requesting port at or
//    after rr pointer (wrapping); req_ack[p]=1, mem_rd/mem_wr pulse next cycle with captured
//    addr/din/wdm; rr pointer <= p+1 mod NUM_PORTS. Enter RUN, cnt=1, busy=1 from next cycle.
//  - Same port read+write: write performed, read dropped, fail<=1.
//  - RUN: cnt increments; at cnt==ACCESS_CYCLES: if read, rd_data<=mem_dout, rd_valid[p]=1,
//    fail<=1 if mem_data_ready=0; state IDLE, busy=0. Next grant earliest the following cycle,
//    so back-to-back accesses every ACCESS_CYCLES+1 cycles.
//  - Refresh occupies RUN for ACCESS_CYCLES, no rd_valid. Refresh pre-empts pending ports only
//    at grant points, never an in-flight access.
//  - total_written increments on write grant, wraps 2^CNT_W-1 -> 0.
//  - Requests deasserted before ack are simply not served; ack pulse is exactly one cycle.
// STRUCTURE
//  - Package mem_ctrl_pkg: state enum {INIT, IDLE, RUN}, op enum {OP_RD, OP_WR, OP_REF}.
//  - Sub-module rr_arbiter #(N): req vector + pointer -> one-hot grant + valid, combinational.
// TESTING
//  - mem_busy held 10 cycles after reset -> busy=1 until 1 cycle after mem_busy=0, no acks.
//  - Port 2 read 0x001234, mem_dout=0xBEEF, data_ready=1 -> ack c0, rd_valid[2], rd_data=0xBEEF
//    at c0+ACCESS_CYCLES, fail=0.
//  - Ports 0,1,3 write simultaneously and hold -> grants 0,1,3 in order, 5 cycles apart,
//    total_written=3.
//  - refresh and port 1 read together -> refresh_ack first, port 1 ack 5 cycles later.
//  - Read with mem_data_ready=0 at sample -> fail=1, stays 1 until reset.
//  - resetn low during RUN -> no rd_valid, state INIT, total_written=0.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the multi-port SDRAM front end.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    RUN
  } state_t;

  typedef enum logic [1:0] {
    OP_RD,
    OP_WR,
    OP_REF
  } op_t;

  // Index width that stays legal (>=1) for single-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             valid
);

  logic [IDX_W-1:0] idx_tmp;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    idx_tmp   = '0;
    for (int i = 0; i < N; i++) begin
      idx_tmp = IDX_W'((int'(ptr) + i) % N);
      if (!valid && req[idx_tmp]) begin
        valid          = 1'b1;
        grant[idx_tmp] = 1'b1;
        grant_idx      = idx_tmp;
      end
    end
  end

endmodule

// File: rtl/multi_port_memory_controller.sv
// Arbitrates NUM_PORTS read/write clients plus refresh onto a single SDRAM driver
// command interface; one access in flight at a time, ACCESS_CYCLES long.
module multi_port_memory_controller
  import mem_ctrl_pkg::*;
#(
  parameter int NUM_PORTS     = 4,
  parameter int ADDR_W        = 22,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 4,
  parameter int CNT_W         = 20
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_PORTS-1:0]            req_read,
  input  logic [NUM_PORTS-1:0]            req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]     req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]     req_din,
  input  logic [NUM_PORTS*(DATA_W/8)-1:0] req_wdm,
  output logic [NUM_PORTS-1:0]            req_ack,
  output logic [NUM_PORTS-1:0]            rd_valid,
  output logic [DATA_W-1:0]               rd_data,
  input  logic                            refresh,
  output logic                            refresh_ack,
  output logic                            busy,
  output logic                            mem_rd,
  output logic                            mem_wr,
  output logic                            mem_refresh,
  output logic [ADDR_W:0]                 mem_addr,
  output logic [DATA_W-1:0]               mem_din,
  output logic [DATA_W/8-1:0]             mem_wdm,
  input  logic                            mem_busy,
  input  logic [DATA_W-1:0]               mem_dout,
  input  logic                            mem_data_ready,
  output logic                            fail,
  output logic [CNT_W-1:0]                total_written
);

  localparam int BE_W     = DATA_W / 8;
  localparam int IDX_W    = clog2_min1(NUM_PORTS);
  localparam int CNT_BITS = clog2_min1(ACCESS_CYCLES + 1);

  logic [ADDR_W-1:0] addr_arr [NUM_PORTS];
  logic [DATA_W-1:0] din_arr  [NUM_PORTS];
  logic [BE_W-1:0]   wdm_arr  [NUM_PORTS];

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    assign din_arr[gi]  = req_din[gi*DATA_W +: DATA_W];
    assign wdm_arr[gi]  = req_wdm[gi*BE_W +: BE_W];
  end

  state_t                state_reg, state_next;
  op_t                   op_reg, op_next;
  logic [CNT_BITS-1:0]   cnt_reg, cnt_next;
  logic [IDX_W-1:0]      port_reg, port_next;
  logic [IDX_W-1:0]      ptr_reg, ptr_next;
  logic [NUM_PORTS-1:0]  ack_reg, ack_next;
  logic [NUM_PORTS-1:0]  rd_valid_reg, rd_valid_next;
  logic [DATA_W-1:0]     rd_data_reg, rd_data_next;
  logic                  refresh_ack_reg, refresh_ack_next;
  logic                  mem_rd_reg, mem_rd_next;
  logic                  mem_wr_reg, mem_wr_next;
  logic                  mem_refresh_reg, mem_refresh_next;
  logic [ADDR_W:0]       mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]     mem_din_reg, mem_din_next;
  logic [BE_W-1:0]       mem_wdm_reg, mem_wdm_next;
  logic                  fail_reg, fail_next;
  logic [CNT_W-1:0]      total_written_reg, total_written_next;

  logic [NUM_PORTS-1:0]  grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_valid;

  rr_arbiter #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (req_read | req_write),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .valid     (grant_valid)
  );

  always_comb begin
    state_next         = state_reg;
    op_next            = op_reg;
    cnt_next           = cnt_reg;
    port_next          = port_reg;
    ptr_next           = ptr_reg;
    ack_next           = '0;
    rd_valid_next      = '0;
    rd_data_next       = rd_data_reg;
    refresh_ack_next   = 1'b0;
    mem_rd_next        = 1'b0;
    mem_wr_next        = 1'b0;
    mem_refresh_next   = 1'b0;
    mem_addr_next      = mem_addr_reg;
    mem_din_next       = mem_din_reg;
    mem_wdm_next       = mem_wdm_reg;
    fail_next          = fail_reg;
    total_written_next = total_written_reg;

    case (state_reg)
      INIT: begin
        if (!mem_busy) state_next = IDLE;
      end
      IDLE: begin
        if (refresh) begin
          refresh_ack_next = 1'b1;
          mem_refresh_next = 1'b1;
          op_next          = OP_REF;
          state_next       = RUN;
          cnt_next         = CNT_BITS'(1);
        end else if (grant_valid) begin
          ack_next      = grant;
          port_next     = grant_idx;
          ptr_next      = (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
          mem_addr_next = {1'b0, addr_arr[grant_idx]};
          mem_din_next  = din_arr[grant_idx];
          mem_wdm_next  = wdm_arr[grant_idx];
          state_next    = RUN;
          cnt_next      = CNT_BITS'(1);
          // A port asking for both gets its write; the read is dropped and flagged.
          if (req_write[grant_idx]) begin
            op_next            = OP_WR;
            mem_wr_next        = 1'b1;
            total_written_next = total_written_reg + 1'b1;
            if (req_read[grant_idx]) fail_next = 1'b1;
          end else begin
            op_next     = OP_RD;
            mem_rd_next = 1'b1;
          end
        end
      end
      RUN: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_BITS'(ACCESS_CYCLES)) begin
          state_next = IDLE;
          if (op_reg == OP_RD) begin
            rd_data_next            = mem_dout;
            rd_valid_next[port_reg] = 1'b1;
            if (!mem_data_ready) fail_next = 1'b1;
          end
        end
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg         <= INIT;
      op_reg            <= OP_RD;
      cnt_reg           <= '0;
      port_reg          <= '0;
      ptr_reg           <= '0;
      ack_reg           <= '0;
      rd_valid_reg      <= '0;
      rd_data_reg       <= '0;
      refresh_ack_reg   <= 1'b0;
      mem_rd_reg        <= 1'b0;
      mem_wr_reg        <= 1'b0;
      mem_refresh_reg   <= 1'b0;
      mem_addr_reg      <= '0;
      mem_din_reg       <= '0;
      mem_wdm_reg       <= '0;
      fail_reg          <= 1'b0;
      total_written_reg <= '0;
    end else begin
      state_reg         <= state_next;
      op_reg            <= op_next;
      cnt_reg           <= cnt_next;
      port_reg          <= port_next;
      ptr_reg           <= ptr_next;
      ack_reg           <= ack_next;
      rd_valid_reg      <= rd_valid_next;
      rd_data_reg       <= rd_data_next;
      refresh_ack_reg   <= refresh_ack_next;
      mem_rd_reg        <= mem_rd_next;
      mem_wr_reg        <= mem_wr_next;
      mem_refresh_reg   <= mem_refresh_next;
      mem_addr_reg      <= mem_addr_next;
      mem_din_reg       <= mem_din_next;
      mem_wdm_reg       <= mem_wdm_next;
      fail_reg          <= fail_next;
      total_written_reg <= total_written_next;
    end
  end

  assign req_ack       = ack_reg;
  assign rd_valid      = rd_valid_reg;
  assign rd_data       = rd_data_reg;
  assign refresh_ack   = refresh_ack_reg;
  assign busy          = (state_reg != IDLE);
  assign mem_rd        = mem_rd_reg;
  assign mem_wr        = mem_wr_reg;
  assign mem_refresh   = mem_refresh_reg;
  assign mem_addr      = mem_addr_reg;
  assign mem_din       = mem_din_reg;
  assign mem_wdm       = mem_wdm_reg;
  assign fail          = fail_reg;
  assign total_written = total_written_reg;

endmodule
